wb_trap_ctrl: RTL and testbench

Parametrised trap controller for the write-back stage. It is the sequential successor to the combinational WB exception encoder. It prioritises synchronous exceptions and a configurable number of interrupt lines, and kills the retiring instruction's register-file write. It also captures mcause/mtval/mepc for the CSR file, flushes the pipeline for a fixed number of cycles, and then redirects fetch through a valid/ready handshake. It sits between the WB stage, the CSR file and the fetch stage.

---
 rtl/wb_trap_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_wb_trap_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trap_ctrl.sv
// wb_trap_ctrl: write-back trap controller.
// Prioritises interrupts, exceptions and MRET; kills the retiring write and
// captures mcause/mtval/mepc. It then flushes younger stages for FLUSH_CYCLES
// cycles and redirects fetch through a valid/ready handshake.
// Optional build macro: WB_TRAP_VECTORED_EN enables vectored interrupt targets
// (mtvec mode 2'b01). Without it the controller is direct mode only.
module wb_trap_ctrl #(
    parameter int XLEN         = 32,
    parameter int NUM_IRQ      = 3,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               retire_valid_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [31:0]        instruction_i,
    input  logic [XLEN-1:0]    mem_addr_i,
    input  logic               e_inst_addr_mis_i,
    input  logic               e_illegal_inst_i,
    input  logic               e_break_i,
    input  logic               e_ecall_i,
    input  logic               e_ld_addr_mis_i,
    input  logic               e_st_addr_mis_i,
    input  logic               is_mret_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] mie_i,
    input  logic               mstatus_mie_i,
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic [XLEN-1:0]    mepc_i,
    output logic               kill_o,
    output logic               csr_we_o,
    output logic               mret_o,
    output logic [XLEN-1:0]    mcause_o,
    output logic [XLEN-1:0]    mtval_o,
    output logic [XLEN-1:0]    mepc_o,
    output logic               flush_o,
    output logic               busy_o,
    output logic               redirect_valid_o,
    output logic [XLEN-1:0]    redirect_pc_o,
    input  logic               redirect_ready_i
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic [NUM_IRQ-1:0] irq_pend;
    logic               irq_any;
    logic               exc_any;
    logic               trap_take;
    logic               mret_take;
    logic [XLEN-1:0]    trap_cause;
    logic [XLEN-1:0]    trap_tval;
    logic [XLEN-1:0]    trap_base;
    logic [XLEN-1:0]    trap_target;

    // Interrupt cause code: MEI > MSI > MTI > local lines, lowest index first.
    function automatic logic [XLEN-1:0] irq_code(input logic [NUM_IRQ-1:0] p);
        logic [XLEN-1:0] c;
        c = '0;
        if (p[2])      c = XLEN'(11);
        else if (p[0]) c = XLEN'(3);
        else if (p[1]) c = XLEN'(7);
        else begin
            // Descending scan so the lowest pending local line wins.
            for (int k = NUM_IRQ - 1; k >= 3; k--) begin
                if (p[k]) c = XLEN'(16 + k - 3);
            end
        end
        return c;
    endfunction

    assign irq_pend  = irq_i & mie_i & {NUM_IRQ{mstatus_mie_i}};
    assign irq_any   = |irq_pend;
    assign exc_any   = e_inst_addr_mis_i | e_illegal_inst_i | e_break_i |
                       e_ecall_i | e_ld_addr_mis_i | e_st_addr_mis_i;
    assign trap_take = (state == IDLE) && retire_valid_i && (irq_any || exc_any);
    assign mret_take = (state == IDLE) && retire_valid_i && is_mret_i &&
                       !irq_any && !exc_any;
    // MRET has no destination register, so only real traps kill the write.
    assign kill_o    = trap_take && !rst_i;
    assign trap_base = {mtvec_i[XLEN-1:2], 2'b00};

    // Cause and trap value selection: interrupt first, then exceptions in order.
    always_comb begin
        trap_cause = '0;
        trap_tval  = '0;
        if (irq_any) begin
            trap_cause           = irq_code(irq_pend);
            trap_cause[XLEN-1]   = 1'b1;
        end else if (e_inst_addr_mis_i) begin
            trap_cause = XLEN'(0);
            trap_tval  = pc_i;
        end else if (e_illegal_inst_i) begin
            trap_cause = XLEN'(2);
            trap_tval  = XLEN'(instruction_i);
        end else if (e_break_i) begin
            trap_cause = XLEN'(3);
            trap_tval  = pc_i;
        end else if (e_ecall_i) begin
            trap_cause = XLEN'(11);
        end else if (e_ld_addr_mis_i) begin
            trap_cause = XLEN'(4);
            trap_tval  = mem_addr_i;
        end else if (e_st_addr_mis_i) begin
            trap_cause = XLEN'(6);
            trap_tval  = mem_addr_i;
        end
    end

`ifdef WB_TRAP_VECTORED_EN
    // Vectored mode offsets interrupts by 4 x cause code; exceptions use base.
    always_comb begin
        trap_target = trap_base;
        if (irq_any && (mtvec_i[1:0] == 2'b01))
            trap_target = trap_base + {trap_cause[XLEN-3:0], 2'b00};
    end
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec_i[1:0];
    assign trap_target       = trap_base;
`endif

    // Trap sequencer: capture on entry, flush countdown, then redirect handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            cnt              <= '0;
            csr_we_o         <= 1'b0;
            mret_o           <= 1'b0;
            flush_o          <= 1'b0;
            busy_o           <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            mcause_o         <= '0;
            mtval_o          <= '0;
            mepc_o           <= '0;
        end else begin
            csr_we_o <= 1'b0;
            mret_o   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trap_take || mret_take) begin
                        state         <= FLUSH;
                        cnt           <= CW'(FLUSH_CYCLES);
                        flush_o       <= 1'b1;
                        busy_o        <= 1'b1;
                        csr_we_o      <= trap_take;
                        mret_o        <= mret_take;
                        redirect_pc_o <= trap_take ? trap_target : mepc_i;
                        if (trap_take) begin
                            mcause_o <= trap_cause;
                            mtval_o  <= trap_tval;
                            mepc_o   <= pc_i;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt == CW'(1)) begin
                        state            <= REDIRECT;
                        flush_o          <= 1'b0;
                        redirect_valid_o <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                REDIRECT: begin
                    if (redirect_ready_i) begin
                        state            <= IDLE;
                        redirect_valid_o <= 1'b0;
                        busy_o           <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_trap_ctrl.sv
// Testbench for wb_trap_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timeline model.
module tb_wb_trap_ctrl;

    localparam int XLEN    = 32;
    localparam int NUM_IRQ = 5;
    localparam int FC      = 3;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               retire_valid_i;
    logic [XLEN-1:0]    pc_i;
    logic [31:0]        instruction_i;
    logic [XLEN-1:0]    mem_addr_i;
    logic               e_inst_addr_mis_i, e_illegal_inst_i, e_break_i;
    logic               e_ecall_i, e_ld_addr_mis_i, e_st_addr_mis_i;
    logic               is_mret_i;
    logic [NUM_IRQ-1:0] irq_i, mie_i;
    logic               mstatus_mie_i;
    logic [XLEN-1:0]    mtvec_i, mepc_i;
    logic               kill_o, csr_we_o, mret_o;
    logic [XLEN-1:0]    mcause_o, mtval_o, mepc_o;
    logic               flush_o, busy_o, redirect_valid_o;
    logic [XLEN-1:0]    redirect_pc_o;
    logic               redirect_ready_i;

    int n_cmp = 0;
    int n_bad = 0;

    wb_trap_ctrl #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .FLUSH_CYCLES(FC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .retire_valid_i(retire_valid_i),
        .pc_i(pc_i), .instruction_i(instruction_i), .mem_addr_i(mem_addr_i),
        .e_inst_addr_mis_i(e_inst_addr_mis_i), .e_illegal_inst_i(e_illegal_inst_i),
        .e_break_i(e_break_i), .e_ecall_i(e_ecall_i),
        .e_ld_addr_mis_i(e_ld_addr_mis_i), .e_st_addr_mis_i(e_st_addr_mis_i),
        .is_mret_i(is_mret_i), .irq_i(irq_i), .mie_i(mie_i),
        .mstatus_mie_i(mstatus_mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .kill_o(kill_o), .csr_we_o(csr_we_o), .mret_o(mret_o),
        .mcause_o(mcause_o), .mtval_o(mtval_o), .mepc_o(mepc_o),
        .flush_o(flush_o), .busy_o(busy_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ph = cycles since trap entry (0 = idle); 1..FC flush, >FC redirect.
    int          ph = 0;
    bit          m_mret = 1'b0;
    logic [31:0] h_cause = '0, h_tval = '0, h_epc = '0, h_tgt = '0;

    function automatic int line_code(input int k);
        if (k == 0) return 3;
        if (k == 1) return 7;
        if (k == 2) return 11;
        return 16 + k - 3;
    endfunction

    task automatic model_eval(output bit is_trap, output bit is_ret,
                              output logic [31:0] c, output logic [31:0] t,
                              output logic [31:0] g);
        logic [NUM_IRQ-1:0] en;
        logic [31:0]        base;
        logic [5:0]         f;
        int                 codes[6];
        logic [31:0]        tv[6];
        int                 order[NUM_IRQ];
        bit                 found;
        int                 code;
        en    = irq_i & mie_i & {NUM_IRQ{mstatus_mie_i}};
        base  = mtvec_i & ~32'h3;
        f     = {e_st_addr_mis_i, e_ld_addr_mis_i, e_ecall_i, e_break_i,
                 e_illegal_inst_i, e_inst_addr_mis_i};
        codes = '{0, 2, 3, 11, 4, 6};
        tv    = '{pc_i, instruction_i, pc_i, 32'h0, mem_addr_i, mem_addr_i};
        order[0] = 2; order[1] = 0; order[2] = 1;
        for (int k = 3; k < NUM_IRQ; k++) order[k] = k;
        is_trap = 1'b0; is_ret = 1'b0; c = '0; t = '0; g = base;
        found = 1'b0; code = 0;
        if (retire_valid_i) begin
            if (en != '0) begin
                for (int i = 0; i < NUM_IRQ; i++)
                    if (!found && en[order[i]]) begin
                        found = 1'b1;
                        code  = line_code(order[i]);
                    end
                is_trap = 1'b1;
                c = 32'h8000_0000 | 32'(code);
`ifdef WB_TRAP_VECTORED_EN
                if (mtvec_i[1:0] == 2'b01) g = base + 32'(4 * code);
`endif
            end else if (f != '0) begin
                for (int i = 0; i < 6; i++)
                    if (!found && f[i]) begin
                        found = 1'b1;
                        c = 32'(codes[i]);
                        t = tv[i];
                    end
                is_trap = 1'b1;
            end else if (is_mret_i) begin
                is_ret = 1'b1;
                g = mepc_i;
            end
        end
    endtask

    // Compare process: check every cycle, then advance the model.
    always @(negedge clk_i) begin
        bit          tr, rt;
        logic [31:0] c, t, g;
        if (rst_i) begin
            chk("rst_kill", kill_o, 0);
            chk("rst_csr_we", csr_we_o, 0);
            chk("rst_mret", mret_o, 0);
            chk("rst_flush", flush_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_rvalid", redirect_valid_o, 0);
            chk("rst_rpc", redirect_pc_o, 0);
            chk("rst_mcause", mcause_o, 0);
            chk("rst_mtval", mtval_o, 0);
            chk("rst_mepc", mepc_o, 0);
            ph = 0; h_cause = '0; h_tval = '0; h_epc = '0; h_tgt = '0;
        end else begin
            model_eval(tr, rt, c, t, g);
            chk("kill", kill_o, (ph == 0) && tr);
            chk("csr_we", csr_we_o, (ph == 1) && !m_mret);
            chk("mret", mret_o, (ph == 1) && m_mret);
            chk("flush", flush_o, (ph >= 1) && (ph <= FC));
            chk("busy", busy_o, ph != 0);
            chk("rvalid", redirect_valid_o, ph > FC);
            if (ph > FC) chk("rpc", redirect_pc_o, h_tgt);
            chk("mcause", mcause_o, h_cause);
            chk("mtval", mtval_o, h_tval);
            chk("mepc", mepc_o, h_epc);
            if (ph == 0) begin
                if (tr || rt) begin
                    ph = 1; m_mret = rt; h_tgt = g;
                    if (tr) begin h_cause = c; h_tval = t; h_epc = pc_i; end
                end
            end else if (ph <= FC) begin
                ph++;
            end else if (redirect_ready_i) begin
                ph = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_i); #1;
    endtask

    task automatic idle_inputs();
        retire_valid_i = 0; e_inst_addr_mis_i = 0; e_illegal_inst_i = 0;
        e_break_i = 0; e_ecall_i = 0; e_ld_addr_mis_i = 0; e_st_addr_mis_i = 0;
        is_mret_i = 0; irq_i = '0; mie_i = '0; mstatus_mie_i = 0;
    endtask

    task automatic wait_rv(input int bound);
        int n;
        n = 0;
        while (redirect_valid_o !== 1'b1 && n < bound) begin @(posedge clk_i); #4; n++; end
        chk("rvalid_timeout", n < bound, 1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < bound) begin @(posedge clk_i); #4; n++; end
        chk("idle_timeout", n < bound, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1; idle_inputs(); redirect_ready_i = 1;
        pc_i = '0; instruction_i = '0; mem_addr_i = '0; mtvec_i = '0; mepc_i = '0;
        repeat (3) step();
        rst_i = 0;
        step();

        // Illegal instruction
        retire_valid_i = 1; e_illegal_inst_i = 1; instruction_i = 32'hFFFF_FFFF;
        pc_i = 32'h100; mtvec_i = 32'h200;
        #3 chk("d1_kill", kill_o, 1);
        step(); idle_inputs();
        #3 chk("d1_csr_we", csr_we_o, 1);
        chk("d1_mcause", mcause_o, 32'h2);
        chk("d1_mtval", mtval_o, 32'hFFFF_FFFF);
        chk("d1_mepc", mepc_o, 32'h100);
        chk("d1_flush", flush_o, 1);
        wait_rv(10);
        chk("d1_rpc", redirect_pc_o, 32'h200);
        wait_idle(10);

        // Interrupt beats ecall
        step();
        retire_valid_i = 1; irq_i = 5'b00111; mie_i = 5'b00101; mstatus_mie_i = 1;
        e_ecall_i = 1; pc_i = 32'h900;
        step(); idle_inputs();
        #3 chk("d2_mcause", mcause_o, 32'h8000_000B);
        chk("d2_mtval", mtval_o, 32'h0);
        chk("d2_mepc", mepc_o, 32'h900);
        wait_idle(10);

        // Handshake hold
        redirect_ready_i = 0;
        step();
        retire_valid_i = 1; e_break_i = 1; pc_i = 32'h44; mtvec_i = 32'h400;
        step(); idle_inputs();
        wait_rv(10);
        for (int i = 0; i < 4; i++) begin
            step(); retire_valid_i = 1; e_break_i = 1; mtvec_i = 32'h7F0;
            #3 chk("d3_rvalid", redirect_valid_o, 1);
            chk("d3_rpc", redirect_pc_o, 32'h400);
            chk("d3_csr_we", csr_we_o, 0);
        end
        step(); idle_inputs(); redirect_ready_i = 1;
        #3 chk("d3_xfer", redirect_valid_o, 1);
        step();
        #3 chk("d3_idle", busy_o, 0);

        // MRET
        step();
        retire_valid_i = 1; is_mret_i = 1; mepc_i = 32'h340;
        #3 chk("d4_kill", kill_o, 0);
        step(); idle_inputs(); mepc_i = 32'h999;
        #3 chk("d4_mret", mret_o, 1);
        chk("d4_csr_we", csr_we_o, 0);
        wait_rv(10);
        chk("d4_rpc", redirect_pc_o, 32'h340);
        wait_idle(10);

        // Reset in the second flush cycle
        step();
        retire_valid_i = 1; e_ld_addr_mis_i = 1; mem_addr_i = 32'h55; pc_i = 32'h60;
        mtvec_i = 32'h300;
        step(); idle_inputs();
        step(); rst_i = 1;
        #1 chk("d5_flush", flush_o, 0);
        chk("d5_busy", busy_o, 0);
        chk("d5_mcause", mcause_o, 0);
        chk("d5_mtval", mtval_o, 0);
        step(); rst_i = 0;
        step();
        retire_valid_i = 1; e_illegal_inst_i = 1; instruction_i = 32'h1234_5678;
        step(); idle_inputs();
        #3 chk("d5_csr_we", csr_we_o, 1);
        chk("d5_mcause2", mcause_o, 32'h2);
        wait_idle(10);

        // Timer interrupt with mtvec mode 01
        step();
        retire_valid_i = 1; irq_i = 5'b00010; mie_i = 5'b00010; mstatus_mie_i = 1;
        mtvec_i = 32'h1001; pc_i = 32'h80;
        step(); idle_inputs();
        #3 chk("d6_mcause", mcause_o, 32'h8000_0007);
        wait_rv(10);
`ifdef WB_TRAP_VECTORED_EN
        chk("d6_rpc", redirect_pc_o, 32'h101C);
`else
        chk("d6_rpc", redirect_pc_o, 32'h1000);
`endif
        wait_idle(10);

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            rst_i             = ($urandom_range(0, 199) == 0);
            retire_valid_i    = $urandom_range(0, 1);
            e_inst_addr_mis_i = ($urandom_range(0, 9) == 0);
            e_illegal_inst_i  = ($urandom_range(0, 9) == 0);
            e_break_i         = ($urandom_range(0, 9) == 0);
            e_ecall_i         = ($urandom_range(0, 9) == 0);
            e_ld_addr_mis_i   = ($urandom_range(0, 9) == 0);
            e_st_addr_mis_i   = ($urandom_range(0, 9) == 0);
            is_mret_i         = ($urandom_range(0, 3) == 0);
            irq_i             = NUM_IRQ'($urandom);
            mie_i             = NUM_IRQ'($urandom);
            mstatus_mie_i     = ($urandom_range(0, 2) == 0);
            pc_i              = $urandom;
            instruction_i     = $urandom;
            mem_addr_i        = $urandom;
            mtvec_i           = $urandom;
            mepc_i            = $urandom;
            redirect_ready_i  = $urandom_range(0, 1);
        end
        step(); rst_i = 0; idle_inputs(); redirect_ready_i = 1;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
